// File: rtl/pipe_mem_responder.sv
// Memory responder shared by the IF and MEM stages: arbitrates fetch and data
// requests onto one multi-cycle single-port word array and drives the stall lines.
module pipe_mem_responder #(
   parameter int ADDR_W = 12,
   parameter int LAT    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_rdy,
   output logic [15:0] i_data,
   input  logic        d_re,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_rdy,
   output logic [15:0] d_rdata,
   output logic        stall_fetch,
   output logic        stall_mem
);
   localparam int               CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              last_data_q;
   logic              port_data_q;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic              i_rdy_q;
   logic              d_rdy_q;
   logic [15:0]       i_data_q;
   logic [15:0]       d_rdata_q;
   logic [15:0]       mem [2**ADDR_W];

   logic              d_req;
   logic              grant_data_d;
   logic [ADDR_W-1:0] addr_d;
   logic              commit;
   logic              unused_addr_hi;

   assign d_req          = d_re | d_we;
   // On a tie the port that did not win last time is served.
   assign grant_data_d   = d_req & (~i_req | ~last_data_q);
   assign addr_d         = grant_data_d ? d_addr[ADDR_W-1:0] : i_addr[ADDR_W-1:0];
   assign commit         = (state_q == ACCESS) && (cnt_q == '0);
   assign unused_addr_hi = ^{i_addr[15:ADDR_W], d_addr[15:ADDR_W]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_data_q <= 1'b0;
         i_rdy_q     <= 1'b0;
         d_rdy_q     <= 1'b0;
         i_data_q    <= '0;
         d_rdata_q   <= '0;
      end else begin
         i_rdy_q <= 1'b0;
         d_rdy_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_req | d_req) begin
                  port_data_q <= grant_data_d;
                  last_data_q <= grant_data_d;
                  wr_q        <= grant_data_d & d_we;
                  addr_q      <= addr_d;
                  wdata_q     <= d_wdata;
                  cnt_q       <= CNT_LOAD;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  if (!wr_q) begin
                     if (port_data_q) d_rdata_q <= mem[addr_q];
                     else             i_data_q  <= mem[addr_q];
                  end
                  i_rdy_q <= ~port_data_q;
                  d_rdy_q <= port_data_q;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset during the commit cycle suppresses the write.
   always_ff @(posedge clk) begin
      if (rst_n && commit && wr_q) mem[addr_q] <= wdata_q;
   end

   assign i_rdy       = i_rdy_q;
   assign d_rdy       = d_rdy_q;
   assign i_data      = i_data_q;
   assign d_rdata     = d_rdata_q;
   assign stall_fetch = i_req & ~i_rdy_q;
   assign stall_mem   = d_req & ~d_rdy_q;

endmodule

// File: tb/tb_pipe_mem_responder.sv
// Randomized bench for pipe_mem_responder against a transaction-level model of
// arbitration order, latency and array contents.
module tb_pipe_mem_responder;
   localparam int ADDR_W = 12;
   localparam int LAT    = 4;
   localparam int BUDGET = 2 * LAT + 12;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_rdy;
   logic [15:0] i_data;
   logic        d_re;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_rdy;
   logic [15:0] d_rdata;
   logic        stall_fetch;
   logic        stall_mem;

   always #5 clk = ~clk;

   pipe_mem_responder #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_data(i_data),
      .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdy(d_rdy), .d_rdata(d_rdata),
      .stall_fetch(stall_fetch), .stall_mem(stall_mem)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [15:0] mdl_mem [2**ADDR_W];
   bit          mdl_last_data;
   logic [15:0] mdl_idata;
   logic [15:0] mdl_drdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      mdl_last_data = 1'b0;
      mdl_idata     = 16'h0000;
      mdl_drdata    = 16'h0000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         i_req   = 1'($urandom_range(0, 1));
         i_addr  = 16'($urandom);
         d_re    = 1'($urandom_range(0, 1));
         d_we    = 1'($urandom_range(0, 1));
         d_addr  = 16'($urandom);
         d_wdata = 16'($urandom);
         @(posedge clk); #1;
      end
      chk("rst_i_rdy", 32'(i_rdy), 0);
      chk("rst_d_rdy", 32'(d_rdy), 0);
      chk("rst_i_data", 32'(i_data), 0);
      chk("rst_d_rdata", 32'(d_rdata), 0);
      rst_n = 1'b1;
      i_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
      model_reset();
   endtask

   // Drives one request set from an idle DUT; each requester drops once it sees rdy.
   task automatic txn(input bit ireq, input logic [15:0] ia, input bit dre, input bit dwe,
                      input logic [15:0] da, input logic [15:0] dw,
                      output int ilat, output int dlat, output logic [15:0] idat,
                      output logic [15:0] ddat, output int istall, output int dstall);
      bit ip, dp;
      int cyc;
      ip = ireq; dp = dre | dwe;
      ilat = -1; dlat = -1; idat = '0; ddat = '0; istall = 0; dstall = 0;
      i_req = ireq; i_addr = ia; d_re = dre; d_we = dwe; d_addr = da; d_wdata = dw;
      cyc = 0;
      while ((ip || dp) && cyc < BUDGET) begin
         @(negedge clk);
         if (stall_fetch) istall++;
         if (stall_mem)   dstall++;
         if (i_rdy) begin
            if (ip) begin ilat = cyc; idat = i_data; ip = 1'b0; end
            else chk("i_rdy_spurious", 1, 0);
         end
         if (d_rdy) begin
            if (dp) begin dlat = cyc; ddat = d_rdata; dp = 1'b0; end
            else chk("d_rdy_spurious", 1, 0);
         end
         @(posedge clk); #1;
         if (!ip) i_req = 1'b0;
         if (!dp) begin d_re = 1'b0; d_we = 1'b0; end
         cyc++;
      end
      i_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
   endtask

   task automatic do_txn(input bit ireq, input logic [15:0] ia, input bit dre, input bit dwe,
                         input logic [15:0] da, input logic [15:0] dw);
      bit          dreq, data_first, serve_data;
      int          e_ilat, e_dlat, ilat, dlat, istall, dstall;
      logic [15:0] idat, ddat;
      dreq   = dre | dwe;
      e_ilat = 0;
      e_dlat = 0;
      data_first = (ireq && dreq) ? !mdl_last_data : dreq;
      for (int k = 0; k < 2; k++) begin
         serve_data = (k == 0) ? data_first : !data_first;
         if (serve_data && dreq) begin
            e_dlat = (k == 0) ? LAT + 1 : 2 * LAT + 3;
            if (dwe) mdl_mem[da[ADDR_W-1:0]] = dw;
            else     mdl_drdata = mdl_mem[da[ADDR_W-1:0]];
            mdl_last_data = 1'b1;
         end else if (!serve_data && ireq) begin
            e_ilat = (k == 0) ? LAT + 1 : 2 * LAT + 3;
            mdl_idata = mdl_mem[ia[ADDR_W-1:0]];
            mdl_last_data = 1'b0;
         end
      end
      txn(ireq, ia, dre, dwe, da, dw, ilat, dlat, idat, ddat, istall, dstall);
      if (ireq) begin
         chk("i_latency", 32'(ilat), 32'(e_ilat));
         chk("i_data", 32'(idat), 32'(mdl_idata));
      end
      if (dreq) begin
         chk("d_latency", 32'(dlat), 32'(e_dlat));
         chk("d_rdata", 32'(ddat), 32'(mdl_drdata));
      end
      chk("stall_fetch_cycles", 32'(istall), 32'(ireq ? e_ilat : 0));
      chk("stall_mem_cycles", 32'(dstall), 32'(dreq ? e_dlat : 0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int rdy_cnt;
      int sel;
      int op;
      rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_re = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0;

      do_reset();
      rdy_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (i_rdy || d_rdy) rdy_cnt++;
         @(posedge clk); #1;
      end
      chk("idle_no_rdy", 32'(rdy_cnt), 0);

      do_txn(1'b0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'h1234);
      do_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);

      do_txn(1'b0, 16'h0, 1'b0, 1'b1, 16'h0003, 16'hBEEF);
      do_txn(1'b1, 16'h0003, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (10) begin @(posedge clk); #1; end
      chk("i_data_hold", 32'(i_data), 32'h0000BEEF);

      do_reset();
      do_txn(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0003, 16'h0);
      do_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
      do_txn(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0010, 16'h0);

      do_txn(1'b0, 16'h0, 1'b0, 1'b1, 16'h1005, 16'hA5A5);
      do_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'h0005, 16'h0);
      do_txn(1'b0, 16'h0, 1'b1, 1'b1, 16'h0007, 16'h00FF);
      do_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'h0007, 16'h0);

      do_txn(1'b0, 16'h0, 1'b0, 1'b1, 16'h0020, 16'h1111);
      rdy_cnt = 0;
      d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h2222;
      for (int c = 0; c < LAT; c++) begin
         @(negedge clk);
         if (d_rdy) rdy_cnt++;
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      d_we  = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (d_rdy || i_rdy) rdy_cnt++;
         @(posedge clk); #1;
      end
      chk("abort_no_rdy", 32'(rdy_cnt), 0);
      do_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);

      // Seed a small address pool (with random aliasing upper bits) for the random mix.
      for (int a = 0; a < 16; a++)
         do_txn(1'b0, 16'h0, 1'b0, 1'b1, {4'($urandom), 12'(a)}, 16'($urandom));
      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(1, 3);
         op  = $urandom_range(0, 2);
         do_txn(sel[0], {4'($urandom), 8'h00, 4'($urandom)},
                sel[1] && (op != 1), sel[1] && (op != 0),
                {4'($urandom), 8'h00, 4'($urandom)}, 16'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_mem_responder.md
# pipe_mem_responder

Memory-side responder for the five-stage pipeline's instruction-fetch and data-memory ports. It arbitrates the two request streams onto one single-port, multi-cycle word array. It returns read data or a write acknowledgement through a ready handshake, and drives the stall signals the hazard logic uses to freeze the pipeline while an access is outstanding. It sits between the IF and MEM stages and replaces the single-cycle instruction and data memories.

## Interface
- ADDR_W, 12, number of word-address bits used; the array holds 2^ADDR_W 16-bit words.
- LAT, 4, array access cycles per request; must be ≥1.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_req  in  1  instruction fetch request; held high with stable i_addr until i_rdy.
- i_addr  in  16  fetch word address.
- i_rdy  out  1  one-cycle pulse: i_data is valid this cycle.
- i_data  out  16  fetched instruction; registered, holds its value until the next fetch response.
- d_re  in  1  data read request.
- d_we  in  1  data write request.
- d_addr  in  16  data word address.
- d_wdata  in  16  store data.
- d_rdy  out  1  one-cycle pulse: data read or write has completed.
- d_rdata  out  16  load data; registered, holds its value until the next data read response.
- stall_fetch  out  1  combinational: i_req & ~i_rdy.
- stall_mem  out  1  combinational: (d_re | d_we) & ~d_rdy.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- IDLE:
  - If neither port is requesting, remain in IDLE.
  - If only one port is requesting, grant it.
  - If both are requesting, grant the port opposite to last_grant.
  - last_grant resets to "instruction", so the first tie goes to data.
- On a grant:
  - Latch port, op (read/write), addr[ADDR_W-1:0] and wdata.
  - Load cnt = LAT-1 and go to ACCESS.
  - Update last_grant.
- ACCESS:
  - If cnt≠0, decrement cnt.
  - If cnt=0, commit at the edge ending that cycle: a write updates the array, a read captures the array word into the granted port's data register. Then go to DONE.
- DONE:
  - Assert rdy on the granted port for exactly one cycle.
  - Return to IDLE; IDLE evaluates requests on the following cycle.
  - A requester that sees rdy advances, so it is never served twice.
- Addressing:
  - Only the low ADDR_W address bits are used; upper bits are ignored, so addresses wrap.
  - The instruction port is read-only.
- d_re and d_we high together is treated as a write; d_rdata is unchanged.
- Requests that drop before rdy:
  - Undefined, because requesters must hold.
  - The latched request still completes, and rdy still pulses.
- Reset:
  - Forces IDLE and clears cnt, last_grant, i_rdy, d_rdy, i_data and d_rdata to 0.
  - Array contents are not reset.
  - Reset in any ACCESS cycle, including the commit cycle, aborts the access: no array write, and no rdy is issued.
- Reset values: i_rdy=0, d_rdy=0, i_data=0x0000, d_rdata=0x0000. stall_fetch and stall_mem follow their inputs.

## Timing
- Request-to-rdy latency is LAT+1 cycles.
  - Request high in IDLE in cycle 0.
  - ACCESS in cycles 1..LAT.
  - rdy in cycle LAT+1.
- Back-to-back accesses take LAT+2 cycles each, because of the DONE→IDLE turnaround.
- The array is written at the rising edge ending the last ACCESS cycle. A read of the same address granted afterwards returns the new value.
- i_data and d_rdata become valid in the rdy cycle and remain stable afterwards.
- stall_* are high from the first cycle a request is present until the cycle before its rdy, inclusive of cycles spent waiting for the other port.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles with random inputs.
  - Required response: i_rdy=d_rdy=0 and i_data=d_rdata=0x0000; then with no requests, no rdy pulse for 20 cycles.
- Write then read, LAT=4:
  - Stimulus: d_we, d_addr=0x0010, d_wdata=0x1234 in cycle 0.
  - Required response: d_rdy only in cycle 5, stall_mem high in cycles 0–4.
  - Then: d_re of 0x0010 in cycle 6 gives d_rdy in cycle 11 with d_rdata=0x1234.
- Fetch:
  - Stimulus: store 0xBEEF at 0x0003 via the data port, then i_req with i_addr=0x0003.
  - Required response: i_rdy exactly LAT+1 cycles after the request with i_data=0xBEEF, and i_data still 0xBEEF 10 cycles later.
- Tie and fairness:
  - Stimulus: i_req and d_re both high from cycle 0 after reset.
  - Required response: d_rdy in cycle 5, i_rdy in cycle 11, stall_fetch high in cycles 0–10.
  - Then: with both held again, the instruction port wins the next tie.
- Wrap and conflict:
  - Stimulus (ADDR_W=12): write 0xA5A5 to 0x1005, then read 0x0005.
  - Required response: the read returns 0xA5A5.
  - Stimulus: d_re=d_we=1 with d_wdata=0x00FF to 0x0007.
  - Required response: treated as a write (0x0007 reads back 0x00FF) and d_rdata unchanged.
- Reset mid-access:
  - Stimulus: store 0x1111 at 0x0020; then start a write of 0x2222 to 0x0020 and pull rst_n low in the final ACCESS cycle.
  - Required response: no d_rdy pulse; a later read of 0x0020 returns 0x1111.
